// File: rtl/walk_pkg.sv
// Shared command field layout, direction codes and controller state codes for the walker.
package walk_pkg;
  localparam logic [1:0] DIR_WEST  = 2'b00;
  localparam logic [1:0] DIR_NORTH = 2'b01;
  localparam logic [1:0] DIR_EAST  = 2'b10;
  localparam logic [1:0] DIR_SOUTH = 2'b11;

  localparam int CMD_W      = 5;
  localparam int CMD_MAG_LO = 0;
  localparam int CMD_MAG_HI = 1;
  localparam int CMD_DIR_LO = 2;
  localparam int CMD_DIR_HI = 3;
  localparam int CMD_HALT   = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  typedef struct packed {
    logic       halt;
    logic [1:0] dir;
    logic [1:0] mag;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [CMD_W-1:0] raw);
    cmd_t c;
    c.halt = raw[CMD_HALT];
    c.dir  = raw[CMD_DIR_HI:CMD_DIR_LO];
    c.mag  = raw[CMD_MAG_HI:CMD_MAG_LO];
    return c;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with flush; read data is the head entry (no bypass), one-cycle push-to-pop.
// Ignores push when full and pop when empty; flush and reset both empty it.
module cmd_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/walk_controller.sv
// Walker position controller: queues move commands, applies one per clock, rejects off-grid moves.
// A command pushed at edge N takes effect at edge N+1 at the earliest; cmd_ready = RUN and FIFO not full.
module walk_controller
  import walk_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = 4,
  parameter int X_MAX = 15,
  parameter int Y_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     x_init,
  input  logic [W-1:0]     y_init,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  output logic             cmd_ready,
  output logic [W-1:0]     x_pos,
  output logic [W-1:0]     y_pos,
  output logic             step_valid,
  output logic             reject,
  output logic             done,
  output logic [7:0]       move_count
);
  localparam logic [W:0]   X_LIM = (W+1)'(X_MAX);
  localparam logic [W:0]   Y_LIM = (W+1)'(Y_MAX);
  localparam logic [W-1:0] X_CLAMP = W'(X_MAX);
  localparam logic [W-1:0] Y_CLAMP = W'(Y_MAX);

  state_t           state;
  logic [CMD_W-1:0] head_raw;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [W:0]       mag_ext;
  logic [W-1:0]     next_x;
  logic [W-1:0]     next_y;
  logic             in_range;

  assign cmd_ready = (state == RUN) && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == RUN) && !fifo_empty && !start;
  assign done      = (state == DONE);
  assign head      = decode_cmd(head_raw);
  assign mag_ext   = (W+1)'(head.mag);

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (start),
    .push    (push),
    .wr_data (cmd),
    .pop     (pop),
    .rd_data (head_raw),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Range check is done one bit wider so adds cannot wrap before the compare.
  always_comb begin
    next_x   = x_pos;
    next_y   = y_pos;
    in_range = 1'b0;
    case (head.dir)
      DIR_WEST: begin
        in_range = {1'b0, x_pos} >= mag_ext;
        next_x   = x_pos - W'(head.mag);
      end
      DIR_EAST: begin
        in_range = ({1'b0, x_pos} + mag_ext) <= X_LIM;
        next_x   = x_pos + W'(head.mag);
      end
      DIR_NORTH: begin
        in_range = ({1'b0, y_pos} + mag_ext) <= Y_LIM;
        next_y   = y_pos + W'(head.mag);
      end
      DIR_SOUTH: begin
        in_range = {1'b0, y_pos} >= mag_ext;
        next_y   = y_pos - W'(head.mag);
      end
      default: in_range = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_pos      <= '0;
      y_pos      <= '0;
      move_count <= '0;
      step_valid <= 1'b0;
      reject     <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      reject     <= 1'b0;
      if (start) begin
        state      <= RUN;
        x_pos      <= (x_init > X_CLAMP) ? X_CLAMP : x_init;
        y_pos      <= (y_init > Y_CLAMP) ? Y_CLAMP : y_init;
        move_count <= '0;
      end else if (pop) begin
        if (head.halt) begin
          state <= DONE;
        end else if (in_range) begin
          x_pos      <= next_x;
          y_pos      <= next_y;
          step_valid <= 1'b1;
          if (move_count != 8'hFF) move_count <= move_count + 8'd1;
        end else begin
          reject <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_walk_controller.sv
// Directed bench for walk_controller: a queue-based grid model is checked against the DUT every cycle,
// with literal expectations at the end of each scenario.
module tb_walk_controller;
  localparam int W = 5;
  localparam int DEPTH = 4;
  localparam int XM = 15;
  localparam int YM = 15;

  localparam logic [4:0] E1 = 5'b01001, E3 = 5'b01011, N0 = 5'b00100, N1 = 5'b00101;
  localparam logic [4:0] N2 = 5'b00110, W1 = 5'b00001, W2 = 5'b00010, S1 = 5'b01101;
  localparam logic [4:0] S3 = 5'b01111, HALT = 5'b10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x_init = '0;
  logic [W-1:0] y_init = '0;
  logic         cmd_valid = 1'b0;
  logic [4:0]   cmd = '0;
  logic         cmd_ready;
  logic [W-1:0] x_pos;
  logic [W-1:0] y_pos;
  logic         step_valid;
  logic         reject;
  logic         done;
  logic [7:0]   move_count;

  walk_controller #(.W(W), .DEPTH(DEPTH), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x_init     (x_init),
    .y_init     (y_init),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .step_valid (step_valid),
    .reject     (reject),
    .done       (done),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;
  int steps_seen = 0;
  int rejects_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
  endtask

  // Model: 0=idle 1=run 2=done; queue holds the buffered commands in order.
  int         m_mode = 0;
  logic [4:0] m_q[$];
  int         m_x = 0, m_y = 0, m_cnt = 0;
  bit         m_step = 0, m_rej = 0;
  int         tx, ty, mag;
  bit         rdy;
  logic [4:0] c;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_q.delete(); m_x = 0; m_y = 0; m_cnt = 0; m_step = 0; m_rej = 0;
    end else begin
      rdy = (m_mode == 1) && (m_q.size() < DEPTH);
      m_step = 0;
      m_rej  = 0;
      if (start) begin
        m_mode = 1;
        m_q.delete();
        m_x = (int'(x_init) > XM) ? XM : int'(x_init);
        m_y = (int'(y_init) > YM) ? YM : int'(y_init);
        m_cnt = 0;
      end else begin
        if (m_mode == 1 && m_q.size() != 0) begin
          c = m_q.pop_front();
          if (c[4]) m_mode = 2;
          else begin
            mag = int'(c[1:0]);
            tx = m_x; ty = m_y;
            case (c[3:2])
              2'b00: tx = tx - mag;
              2'b10: tx = tx + mag;
              2'b01: ty = ty + mag;
              default: ty = ty - mag;
            endcase
            if (tx >= 0 && tx <= XM && ty >= 0 && ty <= YM) begin
              m_x = tx; m_y = ty; m_step = 1;
              if (m_cnt < 255) m_cnt++;
            end else m_rej = 1;
          end
        end
        if (rdy && cmd_valid) m_q.push_back(cmd);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", int'(cmd_ready), int'((m_mode == 1) && (m_q.size() < DEPTH)));
      chk("x_pos", int'(x_pos), m_x);
      chk("y_pos", int'(y_pos), m_y);
      chk("step_valid", int'(step_valid), int'(m_step));
      chk("reject", int'(reject), int'(m_rej));
      chk("done", int'(done), int'(m_mode == 2));
      chk("move_count", int'(move_count), m_cnt);
      if (step_valid) steps_seen++;
      if (reject) rejects_seen++;
    end
  end

  // Called at a negedge; returns at the negedge after the command was accepted.
  task automatic send(input logic [4:0] c_in);
    int n = 0;
    cmd_valid = 1'b1;
    cmd = c_in;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      $display("FAIL send_timeout actual=no_ready expected=ready cmd=%b", c_in);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_start(input int x, input int y);
    start = 1'b1;
    x_init = W'(x);
    y_init = W'(y);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  int s0, r0;
  time t0;

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_x", int'(x_pos), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);

    // Basic walk from (5,5)
    do_start(5, 5);
    s0 = steps_seen;
    send(E3); send(N2); send(W1); send(S3);
    settle();
    chk("t1_x", int'(x_pos), 7);
    chk("t1_y", int'(y_pos), 4);
    chk("t1_count", int'(move_count), 4);
    chk("t1_steps", steps_seen - s0, 4);

    // Underflow rejects at (1,0)
    do_start(1, 0);
    r0 = rejects_seen;
    send(W2); send(S1);
    settle();
    chk("t2_rejects", rejects_seen - r0, 2);
    chk("t2_x", int'(x_pos), 1);
    chk("t2_y", int'(y_pos), 0);
    chk("t2_count", int'(move_count), 0);

    // Upper edge at (14,15)
    do_start(14, 15);
    r0 = rejects_seen;
    send(E1); send(E1); send(N0);
    settle();
    chk("t3_x", int'(x_pos), 15);
    chk("t3_y", int'(y_pos), 15);
    chk("t3_count", int'(move_count), 2);
    chk("t3_rejects", rejects_seen - r0, 1);

    // Offered commands in IDLE are never accepted; then a back-to-back stream
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cmd_valid = 1'b1;
    cmd = E1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_idle_ready", int'(cmd_ready), 0);
    end
    do_start(0, 0);
    cmd_valid = 1'b0;
    t0 = $time;
    send(N0); send(E1); send(E1); send(N1); send(W1); send(S1);
    chk("t4_cycles", int'(($time - t0) / 10), 6);
    settle();
    chk("t4_x", int'(x_pos), 1);
    chk("t4_y", int'(y_pos), 0);
    chk("t4_count", int'(move_count), 6);

    // Halt stops processing; restart flushes the leftover command
    do_start(3, 3);
    send(E1); send(HALT); send(E1);
    settle();
    chk("t5_done", int'(done), 1);
    chk("t5_x", int'(x_pos), 4);
    chk("t5_ready", int'(cmd_ready), 0);
    chk("t5_count", int'(move_count), 1);
    do_start(2, 31);
    chk("t5_rs_done", int'(done), 0);
    chk("t5_rs_y", int'(y_pos), 15);
    settle();
    chk("t5_rs_x", int'(x_pos), 2);
    chk("t5_rs_count", int'(move_count), 0);

    // Saturation, then reset in the middle of a stream
    do_start(0, 0);
    for (int i = 0; i < 300; i++) send(N0);
    settle();
    chk("t6_sat", int'(move_count), 255);
    cmd_valid = 1'b1;
    cmd = N0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    chk("t6_rst_count", int'(move_count), 0);
    chk("t6_rst_step", int'(step_valid), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_ready", int'(cmd_ready), 0);
    repeat (3) @(negedge clk);
    chk("t6_idle_x", int'(x_pos), 0);
    chk("t6_idle_ready", int'(cmd_ready), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
